// File: rtl/pulse_frame_pkg.sv
// Shared state encoding and frame geometry for the pulse-frame transmitter.
// No logic, no latency, no flow control; types and constants only.
package pulse_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         PULSES_PER_FRAME = 4;
    localparam logic [1:0] LAST_PULSE_IDX   = 2'(PULSES_PER_FRAME - 1);

endpackage

// File: rtl/pulse_frame_tx_if.sv
// Burst request channel: valid/ready handshake carrying frame count and gap.
// No storage; start_ready is only high while the transmitter is idle.
interface pulse_frame_tx_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] frame_cnt;
    logic [GAP_W-1:0] gap;

    modport master (output start_valid, frame_cnt, gap, input start_ready);
    modport slave  (input start_valid, frame_cnt, gap, output start_ready);
endinterface

// File: rtl/pulse_frame_tx_gap_timer.sv
// Loadable down-counter; last_o flags the final cycle of a gap (count == 1).
// Load takes effect next cycle; decrement saturates at zero, no flow control.
module pulse_frame_tx_gap_timer #(
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [GAP_W-1:0] load_val_i,
    output logic             last_o
);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/pulse_frame_tx.sv
// Emits frame_cnt frames of four one-cycle x pulses separated by gap low cycles.
// x rises one cycle after accept; requests are accepted only in IDLE, never queued.
module pulse_frame_tx
    import pulse_frame_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    pulse_frame_tx_if.slave  req_if,
    input  logic             abort_i,
    output logic             x_o,
    output logic             frame_tick_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] frames_left_q, frames_left_d;
    logic [1:0]       pulse_idx_q, pulse_idx_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_last;
    logic             last_of_frame;

    assign last_of_frame = (pulse_idx_q == LAST_PULSE_IDX);

    always_comb begin
        state_d       = state_q;
        frames_left_d = frames_left_q;
        pulse_idx_d   = pulse_idx_q;
        gap_reg_d     = gap_reg_q;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_if.start_valid) begin
                    frames_left_d = req_if.frame_cnt;
                    gap_reg_d     = req_if.gap;
                    pulse_idx_d   = '0;
                    state_d       = (req_if.frame_cnt == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                pulse_idx_d = pulse_idx_q + 2'd1;
                if (last_of_frame && (frames_left_q != '0)) begin
                    frames_left_d = frames_left_q - 1'b1;
                end
                if (last_of_frame && (frames_left_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end else if (gap_reg_q == '0) begin
                    state_d = ST_PULSE;
                end else begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_dec = 1'b1;
                if (tmr_last) begin
                    state_d = ST_PULSE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the final pulse, so no done follows.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            frames_left_d = '0;
            pulse_idx_d   = '0;
            tmr_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            frames_left_q <= '0;
            pulse_idx_q   <= '0;
            gap_reg_q     <= '0;
        end else begin
            state_q       <= state_d;
            frames_left_q <= frames_left_d;
            pulse_idx_q   <= pulse_idx_d;
            gap_reg_q     <= gap_reg_d;
        end
    end

    pulse_frame_tx_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .dec_i      (tmr_dec),
        .load_val_i (gap_reg_q),
        .last_o     (tmr_last)
    );

    assign x_o                = (state_q == ST_PULSE);
    assign frame_tick_o       = (state_q == ST_PULSE) && last_of_frame;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);
    assign req_if.start_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pulse_frame_tx.sv
// Randomised burst requests; expected per-cycle output vectors come from a trace model.
module tb_pulse_frame_tx;

    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    // Output vector order: {x, frame_tick, busy, done, start_ready}
    localparam logic [4:0] V_IDLE = 5'b00001;
    localparam logic [4:0] V_GAP  = 5'b00100;
    localparam logic [4:0] V_DONE = 5'b00110;

    logic clk = 1'b0;
    logic reset;
    logic abort_i;
    logic x_o, frame_tick_o, busy_o, done_o;

    pulse_frame_tx_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) req_if ();

    pulse_frame_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_if       (req_if.slave),
        .abort_i      (abort_i),
        .x_o          (x_o),
        .frame_tick_o (frame_tick_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    // Monitor: every cycle the DUT presents an output vector; compare it to the scoreboard head.
    always @(negedge clk) begin
        logic [4:0] exp_v;
        logic [4:0] act_v;
        cyc = cyc + 1;
        if (mon_en) begin
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : V_IDLE;
            act_v = {x_o, frame_tick_o, busy_o, done_o, req_if.start_ready};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL outputs cyc=%0d {x,tick,busy,done,rdy} got=%b exp=%b", cyc, act_v, exp_v);
            end
        end
    end

    function automatic int burst_len(input int n, input int g);
        return (n == 0) ? 1 : (4 * n + (4 * n - 1) * g + 1);
    endfunction

    // Reference: 4n pulses, g lows between consecutive pulses, then one done cycle.
    // A cut at cycle c (abort or reset seen in that cycle) ends the trace after c entries.
    task automatic push_trace(input int n, input int g, input int cut, output int len);
        logic [4:0] tr[$];
        tr = {};
        for (int p = 0; p < 4 * n; p++) begin
            tr.push_back({1'b1, (p % 4 == 3), 1'b1, 1'b0, 1'b0});
            if (p < 4 * n - 1)
                for (int k = 0; k < g; k++) tr.push_back(V_GAP);
        end
        tr.push_back(V_DONE);
        len = tr.size();
        if (cut > 0 && cut < len) len = cut;
        for (int i = 0; i < len; i++) exp_q.push_back(tr[i]);
    endtask

    // mode: 0 normal, 1 abort in cycle 'cut', 2 reset in cycle 'cut'
    task automatic run_req(input int n, input int g, input int mode, input int cut, input bit spurious);
        int len;
        req_if.start_valid = 1'b1;
        req_if.frame_cnt   = CNT_W'(n);
        req_if.gap         = GAP_W'(g);
        abort_i            = 1'($urandom_range(0, 1));
        @(posedge clk);
        push_trace(n, g, (mode != 0) ? cut : 0, len);
        #1;
        for (int k = 1; k <= len; k++) begin
            req_if.start_valid = 1'b0;
            abort_i            = 1'b0;
            reset              = 1'b0;
            if (spurious && k < len && $urandom_range(0, 2) == 0) begin
                req_if.start_valid = 1'b1;
                req_if.frame_cnt   = CNT_W'($urandom_range(0, 15));
                req_if.gap         = GAP_W'($urandom_range(0, 7));
            end
            if (k == cut && mode == 1) abort_i = 1'b1;
            if (k == cut && mode == 2) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        req_if.start_valid = 1'b0;
        abort_i            = 1'b0;
        reset              = 1'b0;
        // Idle spacing; abort here must be ignored.
        repeat ($urandom_range(0, 3)) begin
            abort_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        abort_i = 1'b0;
    endtask

    initial begin
        int n, g, mode, cut;
        reset              = 1'b1;
        abort_i            = 1'b0;
        req_if.start_valid = 1'b1;
        req_if.frame_cnt   = CNT_W'(3);
        req_if.gap         = GAP_W'(1);
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset              = 1'b0;
        req_if.start_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        run_req(2, 0, 0, 0, 1'b0);
        run_req(1, 2, 0, 0, 1'b0);
        run_req(0, 0, 0, 0, 1'b0);
        run_req(3, 1, 1, 1 + 5 * 2, 1'b0);   // abort during the 6th pulse
        run_req(1, 0, 0, 0, 1'b0);
        run_req(2, 1, 0, 0, 1'b1);
        run_req(2, 3, 2, 9, 1'b0);           // reset mid-burst
        run_req(1, 1, 1, burst_len(1, 1) - 1, 1'b0); // abort on final pulse: no done

        for (int i = 0; i < 25; i++) begin
            n    = $urandom_range(0, 5);
            g    = $urandom_range(0, 4);
            mode = ($urandom_range(0, 4) < 3) ? 0 : int'($urandom_range(1, 2));
            cut  = $urandom_range(1, burst_len(n, g));
            run_req(n, g, mode, cut, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain leftover=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
